forward_scoreboard: RTL and testbench

FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

---
 rtl/fwd_pkg.sv | 21 ++
 rtl/forward_scoreboard_if.sv | 37 +++
 rtl/fwd_pend_slot.sv | 33 +++
 rtl/forward_scoreboard.sv | 119 +++++++++++
 tb/tb_forward_scoreboard.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fwd_pkg.sv
// Shared constants and the pending-slot record for the operand forwarding scoreboard.
package fwd_pkg;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 6;
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] dest;
    logic [CNT_W-1:0] cnt;
  } slot_t;

  localparam slot_t SLOT_IDLE = '{vld: 1'b0, dest: {REG_W{1'b0}}, cnt: {CNT_W{1'b0}}};

  // A zero latency still occupies the slot for one cycle.
  function automatic logic [CNT_W-1:0] lat_load(input logic [CNT_W-1:0] cycles);
    return (cycles == {CNT_W{1'b0}}) ? CNT_W'(1) : cycles;
  endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// Source/stage/issue bundle between the issue stage (master) and the forwarding scoreboard (slave).
interface forward_scoreboard_if #(
  parameter int NSRC  = 2,
  parameter int NFWD  = 2,
  parameter int REG_W = 5,
  parameter int CNT_W = 6
);
  localparam int SEL_W = $clog2(NFWD + 1);

  logic [NSRC*REG_W-1:0] src_reg;
  logic [NSRC-1:0]       src_vld;
  logic [NFWD*REG_W-1:0] stg_dest;
  logic [NFWD-1:0]       stg_wen;
  logic [NFWD-1:0]       stg_rdy;
  logic                  lat_issue;
  logic [REG_W-1:0]      lat_dest;
  logic [CNT_W-1:0]      lat_cycles;
  logic                  lat_ack;
  logic                  flush;
  logic [NSRC*SEL_W-1:0] fwd_sel;
  logic                  stall;
  logic                  pend_full;
  logic [31:0]           stall_cnt;

  modport master (
    output src_reg, src_vld, stg_dest, stg_wen, stg_rdy,
    output lat_issue, lat_dest, lat_cycles, flush,
    input  lat_ack, fwd_sel, stall, pend_full, stall_cnt
  );

  modport slave (
    input  src_reg, src_vld, stg_dest, stg_wen, stg_rdy,
    input  lat_issue, lat_dest, lat_cycles, flush,
    output lat_ack, fwd_sel, stall, pend_full, stall_cnt
  );

endinterface

// File: rtl/fwd_pend_slot.sv
// One pending long-latency result: holds its destination and counts down until it
// reaches the oldest bypass stage.
module fwd_pend_slot
  import fwd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic [REG_W-1:0] load_dest,
  input  logic [CNT_W-1:0] load_cnt,
  output logic             vld,
  output logic [REG_W-1:0] dest
);

  slot_t slot_r;

  // Load, count down, and retire when the count reaches one; flush beats load and retire.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      slot_r <= SLOT_IDLE;
    end else if (load) begin
      slot_r <= '{vld: 1'b1, dest: load_dest, cnt: lat_load(load_cnt)};
    end else if (slot_r.vld) begin
      slot_r.vld <= (slot_r.cnt != CNT_W'(1));
      slot_r.cnt <= slot_r.cnt - CNT_W'(1);
    end
  end

  assign vld  = slot_r.vld;
  assign dest = slot_r.dest;

endmodule

// File: rtl/forward_scoreboard.sv
// Operand bypass selection and hazard stall for an in-order pipeline, with a small
// table of pending long-latency (mul/div) destinations.
module forward_scoreboard #(
  parameter int NSRC  = 2,
  parameter int NFWD  = 2,
  parameter int DEPTH = 2,
  parameter int REG_W = fwd_pkg::REG_W,
  parameter int CNT_W = fwd_pkg::CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  forward_scoreboard_if.slave bus
);

  localparam int SEL_W = $clog2(NFWD + 1);

  logic             vld_s  [DEPTH];
  logic [REG_W-1:0] dest_s [DEPTH];
  logic [DEPTH-1:0] first_free_s;
  logic [DEPTH-1:0] load_s;
  logic [CNT_W-1:0] lat_cycles_s;
  logic [REG_W-1:0] src_s;
  logic [SEL_W:0]   pick_s;
  logic [NSRC*SEL_W-1:0] fwd_sel_s;
  logic             stall_s;
  logic             pend_full_s;
  logic             lat_ack_s;
  logic             alloc_s;
  logic             found_s;
  logic [31:0]      stall_cnt_r;

  // Returns {stall, sel}: the youngest writer decides; a not-ready youngest writer
  // stalls instead of falling back to an older copy.
  function automatic logic [SEL_W:0] stage_pick(
    input logic [REG_W-1:0]      src,
    input logic [NFWD*REG_W-1:0] dest,
    input logic [NFWD-1:0]       wen,
    input logic [NFWD-1:0]       rdy
  );
    logic [SEL_W-1:0] sel;
    logic             stl;
    logic             hit;
    sel = SEL_W'(fwd_pkg::SEL_RF);
    stl = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      hit = wen[k] && (dest[k*REG_W +: REG_W] == src);
      sel = hit ? (rdy[k] ? SEL_W'(k + 1) : SEL_W'(fwd_pkg::SEL_RF)) : sel;
      stl = hit ? ~rdy[k] : stl;
    end
    return {stl, sel};
  endfunction

  // Per-source bypass select plus stage and pending-slot hazards.
  always_comb begin
    fwd_sel_s = {(NSRC*SEL_W){1'b0}};
    stall_s   = 1'b0;
    src_s     = {REG_W{1'b0}};
    pick_s    = {(SEL_W+1){1'b0}};
    for (int i = 0; i < NSRC; i++) begin
      src_s  = bus.src_reg[i*REG_W +: REG_W];
      pick_s = stage_pick(src_s, bus.stg_dest, bus.stg_wen, bus.stg_rdy);
      if (bus.src_vld[i] && (src_s != {REG_W{1'b0}})) begin
        fwd_sel_s[i*SEL_W +: SEL_W] = pick_s[SEL_W-1:0];
        stall_s = stall_s | pick_s[SEL_W];
        for (int d = 0; d < DEPTH; d++) begin
          stall_s = stall_s | (vld_s[d] && (dest_s[d] == src_s));
        end
      end else begin
        fwd_sel_s[i*SEL_W +: SEL_W] = SEL_W'(fwd_pkg::SEL_RF);
      end
    end
  end

  // Lowest-index free slot, from start-of-cycle state.
  always_comb begin
    first_free_s = {DEPTH{1'b0}};
    found_s      = 1'b0;
    pend_full_s  = 1'b1;
    for (int d = 0; d < DEPTH; d++) begin
      first_free_s[d] = ~vld_s[d] & ~found_s;
      found_s         = found_s | ~vld_s[d];
      pend_full_s     = pend_full_s & vld_s[d];
    end
  end

  assign lat_ack_s    = bus.lat_issue & ~pend_full_s & ~stall_s & ~bus.flush & ~rst;
  assign alloc_s      = lat_ack_s & (bus.lat_dest != {REG_W{1'b0}});
  assign load_s       = first_free_s & {DEPTH{alloc_s}};
  assign lat_cycles_s = bus.lat_cycles;

  for (genvar d = 0; d < DEPTH; d++) begin : g_slot
    fwd_pend_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .flush     (bus.flush),
      .load      (load_s[d]),
      .load_dest (bus.lat_dest),
      .load_cnt  (lat_cycles_s),
      .vld       (vld_s[d]),
      .dest      (dest_s[d])
    );
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  assign bus.fwd_sel   = rst ? {(NSRC*SEL_W){1'b0}} : fwd_sel_s;
  assign bus.stall     = stall_s & ~rst;
  assign bus.pend_full = pend_full_s & ~rst;
  assign bus.lat_ack   = lat_ack_s;
  assign bus.stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: directed cycles push expected outputs,
// a negedge monitor pops and compares them.
module tb_forward_scoreboard;

  localparam int NSRC  = 2;
  localparam int NFWD  = 2;
  localparam int DEPTH = 2;
  localparam int REG_W = 5;
  localparam int CNT_W = 6;
  localparam int SEL_W = 2;

  typedef struct {
    string                 name;
    logic [NSRC*SEL_W-1:0] sel;
    logic                  stall;
    logic                  ack;
    logic                  full;
    logic [31:0]           cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          n_cmp;
  int          n_bad;
  logic [31:0] exp_cnt;

  forward_scoreboard_if #(.NSRC(NSRC), .NFWD(NFWD), .REG_W(REG_W), .CNT_W(CNT_W)) bus_if ();

  forward_scoreboard #(
    .NSRC(NSRC), .NFWD(NFWD), .DEPTH(DEPTH), .REG_W(REG_W), .CNT_W(CNT_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, want);
    end
  endtask

  // Monitor: one expected record per driven cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.name, "fwd_sel",   32'(bus_if.fwd_sel),   32'(mon_e.sel));
      chk(mon_e.name, "stall",     32'(bus_if.stall),     32'(mon_e.stall));
      chk(mon_e.name, "lat_ack",   32'(bus_if.lat_ack),   32'(mon_e.ack));
      chk(mon_e.name, "pend_full", 32'(bus_if.pend_full), 32'(mon_e.full));
      chk(mon_e.name, "stall_cnt", bus_if.stall_cnt,      mon_e.cnt);
    end
  end

  task automatic idle_inputs();
    bus_if.src_reg    = '0;
    bus_if.src_vld    = '0;
    bus_if.stg_dest   = '0;
    bus_if.stg_wen    = '0;
    bus_if.stg_rdy    = '0;
    bus_if.lat_issue  = 1'b0;
    bus_if.lat_dest   = '0;
    bus_if.lat_cycles = '0;
    bus_if.flush      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic src(input int i, input logic [REG_W-1:0] r);
    bus_if.src_reg[i*REG_W +: REG_W] = r;
    bus_if.src_vld[i] = 1'b1;
  endtask

  task automatic stg(input int k, input logic [REG_W-1:0] d, input logic rdy);
    bus_if.stg_dest[k*REG_W +: REG_W] = d;
    bus_if.stg_wen[k] = 1'b1;
    bus_if.stg_rdy[k] = rdy;
  endtask

  task automatic issue(input logic [REG_W-1:0] d, input logic [CNT_W-1:0] c);
    bus_if.lat_issue  = 1'b1;
    bus_if.lat_dest   = d;
    bus_if.lat_cycles = c;
  endtask

  // Expected stall_cnt is the number of stalled cycles seen before this one.
  task automatic expect_out(input string nm, input logic [3:0] sel, input logic stl,
                            input logic ack, input logic full);
    exp_t e;
    e.name  = nm;
    e.sel   = sel;
    e.stall = stl;
    e.ack   = ack;
    e.full  = full;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    if (rst) exp_cnt = 32'd0;
    else if (stl) exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    exp_cnt = 32'd0;
    rst     = 1'b1;
    idle_inputs();

    // Reset held with a live hazard and an issue request
    next_cycle(); rst = 1'b1; src(0, 5'd3); stg(0, 5'd3, 1'b0); issue(5'd5, 6'd4);
    expect_out("rst_hold", 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); expect_out("idle", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Bypass selection
    next_cycle(); src(0, 5'd3); stg(0, 5'd3, 1'b1); stg(1, 5'd3, 1'b1);
    expect_out("youngest", 4'b0001, 1'b0, 1'b0, 1'b0);
    next_cycle(); src(1, 5'd7); stg(0, 5'd7, 1'b0); stg(1, 5'd7, 1'b1);
    expect_out("load_use", 4'b0000, 1'b1, 1'b0, 1'b0);
    next_cycle(); expect_out("cnt_inc", 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); src(0, 5'd4); src(1, 5'd6); stg(0, 5'd6, 1'b1); stg(1, 5'd4, 1'b1);
    expect_out("mixed", 4'b0110, 1'b0, 1'b0, 1'b0);
    next_cycle(); bus_if.src_reg[4:0] = 5'd4; stg(0, 5'd4, 1'b1);
    expect_out("no_vld", 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); src(0, 5'd8); bus_if.stg_dest[4:0] = 5'd8; bus_if.stg_rdy[0] = 1'b1; stg(1, 5'd8, 1'b1);
    expect_out("wen_off", 4'b0010, 1'b0, 1'b0, 1'b0);

    // Pending slot countdown: three stall cycles then clear
    next_cycle(); issue(5'd9, 6'd3); expect_out("iss9", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); src(0, 5'd9); expect_out("pend9_1", 4'b0000, 1'b1, 1'b0, 1'b0);
    next_cycle(); src(0, 5'd9); expect_out("pend9_2", 4'b0000, 1'b1, 1'b0, 1'b0);
    next_cycle(); src(0, 5'd9); expect_out("pend9_3", 4'b0000, 1'b1, 1'b0, 1'b0);
    next_cycle(); src(0, 5'd9); expect_out("pend9_4", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Fill, full, retire cycle still full, then freed
    next_cycle(); issue(5'd10, 6'd3); expect_out("fill_a", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); issue(5'd11, 6'd5); expect_out("fill_b", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); issue(5'd12, 6'd4); expect_out("full", 4'b0000, 1'b0, 1'b0, 1'b1);
    next_cycle(); issue(5'd12, 6'd4); expect_out("full_retire", 4'b0000, 1'b0, 1'b0, 1'b1);
    next_cycle(); issue(5'd12, 6'd4); expect_out("freed", 4'b0000, 1'b0, 1'b1, 1'b0);

    // Flush beats issue; old dests no longer stall
    next_cycle(); bus_if.flush = 1'b1; issue(5'd13, 6'd2);
    expect_out("flush", 4'b0000, 1'b0, 1'b0, 1'b1);
    next_cycle(); src(0, 5'd11); src(1, 5'd12);
    expect_out("post_flush", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Dest 0 acks without a slot; zero latency behaves as one
    next_cycle(); issue(5'd0, 6'd5); expect_out("dest0", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); issue(5'd14, 6'd0); expect_out("cyc0", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); issue(5'd15, 6'd7); expect_out("no_alloc0", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); src(0, 5'd14); expect_out("cyc0_done", 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); src(1, 5'd15); issue(5'd16, 6'd2);
    expect_out("pend_blk", 4'b0000, 1'b1, 1'b0, 1'b0);

    // Register 0 never forwards
    next_cycle(); src(0, 5'd0); stg(0, 5'd0, 1'b1);
    expect_out("r0", 4'b0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation with both slots live
    next_cycle(); issue(5'd20, 6'd9); expect_out("live_a", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); rst = 1'b1; src(0, 5'd20); stg(0, 5'd20, 1'b1); issue(5'd21, 6'd3);
    expect_out("rst_live", 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); src(0, 5'd20); src(1, 5'd15);
    expect_out("after_rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    next_cycle(); issue(5'd22, 6'd2); expect_out("re_a", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); issue(5'd23, 6'd2); expect_out("re_b", 4'b0000, 1'b0, 1'b1, 1'b0);
    next_cycle(); src(0, 5'd22); expect_out("re_stall", 4'b0000, 1'b1, 1'b0, 1'b1);
    next_cycle(); expect_out("cnt_restart", 4'b0000, 1'b0, 1'b0, 1'b0);

    next_cycle();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
